// File: rtl/fpu_pkg.sv
// Shared definitions for the sequential floating-point add/sub unit:
// FSM encodings, operand classes and width/constant helpers.
package fpu_pkg;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_UNPACK = 3'd1;
  localparam logic [2:0] S_ALIGN  = 3'd2;
  localparam logic [2:0] S_ADD    = 3'd3;
  localparam logic [2:0] S_NORM   = 3'd4;
  localparam logic [2:0] S_ROUND  = 3'd5;
  localparam logic [2:0] S_DONE   = 3'd6;

  typedef enum logic [2:0] {
    CLS_ZERO, CLS_NORM, CLS_INF, CLS_QNAN, CLS_SNAN
  } cls_e;

  localparam int unsigned MAX_W = 64;

  function automatic int unsigned word_w(input int unsigned exp_w, input int unsigned man_w);
    return 1 + exp_w + man_w;
  endfunction

  // Positive quiet NaN: exponent all-ones, only the fraction MSB set.
  function automatic logic [MAX_W-1:0] canon_qnan(input int unsigned exp_w, input int unsigned man_w);
    logic [MAX_W-1:0] ones;
    ones = (MAX_W'(1) << exp_w) - MAX_W'(1);
    return (ones << man_w) | (MAX_W'(1) << (man_w - 1));
  endfunction

endpackage

// File: rtl/fpu_lzc.sv
// Combinational leading-zero counter; an all-zero input returns WIDTH.
module fpu_lzc #(
  parameter int unsigned WIDTH = 27
) (
  input  logic [WIDTH-1:0]           din_i,
  output logic [$clog2(WIDTH+1)-1:0] cnt_o
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  // Scan upward so the highest set bit wins.
  always_comb begin
    cnt_o = CNT_W'(WIDTH);
    for (int i = 0; i < int'(WIDTH); i++) begin
      if (din_i[i]) cnt_o = CNT_W'(int'(WIDTH) - 1 - i);
    end
  end

endmodule

// File: rtl/fpu_addsub_seq.sv
// Multi-cycle IEEE-754-style adder/subtractor with RNE rounding, flush-to-zero
// and exception flags, behind a valid/busy/ready handshake (fixed latency 5).
module fpu_addsub_seq import fpu_pkg::*; #(
  parameter  int unsigned EXP_W = 8,
  parameter  int unsigned MAN_W = 23,
  localparam int unsigned W     = word_w(EXP_W, MAN_W)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] din1,
  input  logic [W-1:0] din2,
  input  logic         op,
  input  logic         valid,
  output logic         busy,
  output logic [W-1:0] result,
  output logic         ready,
  output logic         flag_inv,
  output logic         flag_ovf,
  output logic         flag_unf
);

  localparam int unsigned DW  = MAN_W + 4;
  localparam int unsigned SW  = DW + 1;
  localparam int unsigned EW  = EXP_W + 2;
  localparam int unsigned LZW = $clog2(DW + 1);
  localparam logic [W-1:0]     QNAN = W'(canon_qnan(EXP_W, MAN_W));
  localparam logic [W-1:0]     QBIT = W'(1) << (MAN_W - 1);
  localparam logic [EXP_W-1:0] EMAX = '1;

  function automatic cls_e classify(input logic [W-1:0] x);
    if (x[W-2:MAN_W] == '0) return CLS_ZERO;
    if (x[W-2:MAN_W] != '1) return CLS_NORM;
    if (x[MAN_W-1:0] == '0) return CLS_INF;
    return x[MAN_W-1] ? CLS_QNAN : CLS_SNAN;
  endfunction

  logic [2:0]             state_q, state_d;
  logic                   busy_d, ready_d, busy_q, ready_q;
  logic [W-1:0]           a_q, b_q, result_q, res_d;
  logic                   op_q;
  logic                   inv_q, ovf_q, unf_o_q, inv_d, ovf_d, unf_o_d;
  logic                   sa_q, sb_q, sa_d, sb_d;
  logic [EXP_W-1:0]       ea_q, eb_q, ea_d, eb_d;
  logic [DW-1:0]          ma_q, mb_q, ma_d, mb_d;
  logic                   spec_q, spec_inv_q, spec_d, spec_inv_d;
  logic [W-1:0]           spec_res_q, spec_res_d;
  cls_e                   ca, cb;
  logic                   a_nan, b_nan;
  logic                   a_ge, s_q, s_d, sub_q, sub_d;
  logic [EXP_W-1:0]       e_q, e_d, diff;
  logic [DW-1:0]          mbig_q, mbig_d, msml_q, msml_d, m_sml, sh;
  logic [SW-1:0]          sum_q, sum_d;
  logic [LZW-1:0]         lz;
  logic [DW-1:0]          nm_q, nm_d;
  logic signed [EW-1:0]   ne_q, ne_d, e_ext, ef;
  logic                   zero_q, zero_d, unf_q, unf_d, rup;
  logic [MAN_W+1:0]       mant;
  logic [MAN_W-1:0]       frac;

  // Sequencer: one state per datapath stage.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (valid) state_d = S_UNPACK;
      S_UNPACK: state_d = S_ALIGN;
      S_ALIGN:  state_d = S_ADD;
      S_ADD:    state_d = S_NORM;
      S_NORM:   state_d = S_ROUND;
      S_ROUND:  state_d = S_DONE;
      default:  state_d = S_IDLE;
    endcase
    busy_d  = (state_d != S_IDLE) && (state_d != S_DONE);
    ready_d = (state_d == S_DONE);
  end

  // UNPACK: classify, apply effective sign of B, resolve special operands.
  always_comb begin
    ca    = classify(a_q);
    cb    = classify(b_q);
    a_nan = ca inside {CLS_QNAN, CLS_SNAN};
    b_nan = cb inside {CLS_QNAN, CLS_SNAN};
    sa_d  = a_q[W-1];
    sb_d  = b_nan ? b_q[W-1] : (b_q[W-1] ^ op_q);
    ea_d  = (ca == CLS_ZERO) ? '0 : a_q[W-2:MAN_W];
    eb_d  = (cb == CLS_ZERO) ? '0 : b_q[W-2:MAN_W];
    ma_d  = (ca == CLS_ZERO) ? '0 : {1'b1, a_q[MAN_W-1:0], 3'b000};
    mb_d  = (cb == CLS_ZERO) ? '0 : {1'b1, b_q[MAN_W-1:0], 3'b000};
    spec_d     = 1'b1;
    spec_inv_d = (ca == CLS_SNAN) || (cb == CLS_SNAN);
    spec_res_d = '0;
    if (a_nan)                spec_res_d = a_q | QBIT;
    else if (b_nan)           spec_res_d = b_q | QBIT;
    else if ((ca == CLS_INF) && (cb == CLS_INF)) begin
      if (sa_d != sb_d) begin
        spec_res_d = QNAN;
        spec_inv_d = 1'b1;
      end else begin
        spec_res_d = {sa_d, b_q[W-2:0]};
      end
    end
    else if (ca == CLS_INF)   spec_res_d = a_q;
    else if (cb == CLS_INF)   spec_res_d = {sb_d, b_q[W-2:0]};
    else if ((ca == CLS_ZERO) && (cb == CLS_ZERO)) spec_res_d = {sa_d & sb_d, (W-1)'(0)};
    else                      spec_d = 1'b0;
  end

  // ALIGN: order by magnitude, shift the smaller operand keeping a sticky bit.
  always_comb begin
    a_ge   = {ea_q, ma_q} >= {eb_q, mb_q};
    s_d    = a_ge ? sa_q : sb_q;
    e_d    = a_ge ? ea_q : eb_q;
    mbig_d = a_ge ? ma_q : mb_q;
    m_sml  = a_ge ? mb_q : ma_q;
    diff   = a_ge ? (ea_q - eb_q) : (eb_q - ea_q);
    sh     = m_sml >> diff;
    msml_d = sh | DW'((sh << diff) != m_sml);
    sub_d  = sa_q ^ sb_q;
  end

  assign sum_d = sub_q ? ({1'b0, mbig_q} - {1'b0, msml_q})
                       : ({1'b0, mbig_q} + {1'b0, msml_q});

  fpu_lzc #(.WIDTH(DW)) u_lzc (
    .din_i (sum_q[DW-1:0]),
    .cnt_o (lz)
  );

  // NORM: fold carry-out or remove leading zeros; detect flush-to-zero.
  always_comb begin
    e_ext = $signed({2'b00, e_q});
    if (sum_q[SW-1]) begin
      nm_d = sum_q[SW-1:1] | DW'(sum_q[0]);
      ne_d = e_ext + $signed(EW'(1));
    end else begin
      nm_d = sum_q[DW-1:0] << lz;
      ne_d = e_ext - $signed(EW'(lz));
    end
    zero_d = (sum_q == '0);
    unf_d  = !zero_d && (ne_d <= 0);
  end

  // ROUND: nearest-even on guard/round/sticky, then pick the final encoding.
  always_comb begin
    rup  = nm_q[2] & (nm_q[1] | nm_q[0] | nm_q[3]);
    mant = {1'b0, nm_q[DW-1:3]} + (MAN_W+2)'(rup);
    ef   = ne_q + $signed(EW'(mant[MAN_W+1]));
    frac = mant[MAN_W+1] ? mant[MAN_W:1] : mant[MAN_W-1:0];
    res_d   = {s_q, ef[EXP_W-1:0], frac};
    inv_d   = 1'b0;
    ovf_d   = 1'b0;
    unf_o_d = 1'b0;
    if (spec_q) begin
      res_d = spec_res_q;
      inv_d = spec_inv_q;
    end else if (zero_q) begin
      res_d = '0;
    end else if (unf_q) begin
      res_d   = {s_q, (W-1)'(0)};
      unf_o_d = 1'b1;
    end else if (ef >= $signed({2'b00, EMAX})) begin
      res_d = {s_q, EMAX, MAN_W'(0)};
      ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      busy_q <= 1'b0; ready_q <= 1'b0; result_q <= '0;
      inv_q <= 1'b0; ovf_q <= 1'b0; unf_o_q <= 1'b0;
      a_q <= '0; b_q <= '0; op_q <= 1'b0;
      sa_q <= 1'b0; sb_q <= 1'b0; ea_q <= '0; eb_q <= '0; ma_q <= '0; mb_q <= '0;
      spec_q <= 1'b0; spec_inv_q <= 1'b0; spec_res_q <= '0;
      s_q <= 1'b0; e_q <= '0; mbig_q <= '0; msml_q <= '0; sub_q <= 1'b0;
      sum_q <= '0; nm_q <= '0; ne_q <= '0; zero_q <= 1'b0; unf_q <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      ready_q <= ready_d;
      if ((state_q == S_IDLE) && valid) begin
        a_q <= din1; b_q <= din2; op_q <= op;
      end
      if (state_q == S_UNPACK) begin
        sa_q <= sa_d; sb_q <= sb_d; ea_q <= ea_d; eb_q <= eb_d; ma_q <= ma_d; mb_q <= mb_d;
        spec_q <= spec_d; spec_inv_q <= spec_inv_d; spec_res_q <= spec_res_d;
      end
      if (state_q == S_ALIGN) begin
        s_q <= s_d; e_q <= e_d; mbig_q <= mbig_d; msml_q <= msml_d; sub_q <= sub_d;
      end
      if (state_q == S_ADD) sum_q <= sum_d;
      if (state_q == S_NORM) begin
        nm_q <= nm_d; ne_q <= ne_d; zero_q <= zero_d; unf_q <= unf_d;
      end
      if (state_q == S_ROUND) begin
        result_q <= res_d; inv_q <= inv_d; ovf_q <= ovf_d; unf_o_q <= unf_o_d;
      end
    end
  end

  assign busy     = busy_q;
  assign ready    = ready_q;
  assign result   = result_q;
  assign flag_inv = inv_q;
  assign flag_ovf = ovf_q;
  assign flag_unf = unf_o_q;

endmodule

// File: tb/tb_fpu_addsub_seq.sv
// Directed vector bench for fpu_addsub_seq in single-precision configuration.
module tb_fpu_addsub_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] din1, din2, result;
  logic        op, valid, busy, ready, flag_inv, flag_ovf, flag_unf;

  int total = 0;
  int bad   = 0;

  fpu_addsub_seq #(.EXP_W(8), .MAN_W(23)) dut (
    .clk(clk), .reset(reset), .din1(din1), .din2(din2), .op(op), .valid(valid),
    .busy(busy), .result(result), .ready(ready),
    .flag_inv(flag_inv), .flag_ovf(flag_ovf), .flag_unf(flag_unf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        o;
    logic [31:0] exp;
    logic [2:0]  fl;   // {inv, ovf, unf}
  } vec_t;

  localparam int NV = 20;
  vec_t vecs [NV];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  // Issue one request and check the handshake cycle by cycle, then the result.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic o,
                        input logic [31:0] exp, input logic [2:0] fl, input int id);
    @(negedge clk);
    din1 = a; din2 = b; op = o; valid = 1'b1;
    @(posedge clk); #1;
    valid = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      if (c > 1) begin @(posedge clk); #1; end
      check($sformatf("v%0d busy c%0d", id, c), 32'(busy), 32'(c <= 5));
      check($sformatf("v%0d ready c%0d", id, c), 32'(ready), 32'(c == 6));
    end
    check($sformatf("v%0d result", id), result, exp);
    check($sformatf("v%0d flags", id), 32'({flag_inv, flag_ovf, flag_unf}), 32'(fl));
    @(posedge clk); #1;
    check($sformatf("v%0d ready drop", id), 32'(ready), 32'(0));
  endtask

  initial begin
    int          pulses;
    logic [31:0] seen;

    vecs[0]  = '{32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 3'b000};
    vecs[1]  = '{32'h40400000, 32'h3F800000, 1'b0, 32'h40800000, 3'b000};
    vecs[2]  = '{32'h3F800000, 32'h3F7FFFFF, 1'b1, 32'h33800000, 3'b000};
    vecs[3]  = '{32'h7F800000, 32'h7F800000, 1'b1, 32'h7FC00000, 3'b100};
    vecs[4]  = '{32'h7F800000, 32'hFF800000, 1'b0, 32'h7FC00000, 3'b100};
    vecs[5]  = '{32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 3'b010};
    vecs[6]  = '{32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 3'b000};
    vecs[7]  = '{32'h3F800001, 32'h33800000, 1'b0, 32'h3F800002, 3'b000};
    vecs[8]  = '{32'h3F800000, 32'h7FA00000, 1'b1, 32'h7FE00000, 3'b100};
    vecs[9]  = '{32'h3F800000, 32'h40000000, 1'b1, 32'hBF800000, 3'b000};
    vecs[10] = '{32'h00800001, 32'h00800000, 1'b1, 32'h00000000, 3'b001};
    vecs[11] = '{32'h80000000, 32'h80000000, 1'b0, 32'h80000000, 3'b000};
    vecs[12] = '{32'h00000000, 32'h00000000, 1'b1, 32'h00000000, 3'b000};
    vecs[13] = '{32'h00400000, 32'h3F800000, 1'b0, 32'h3F800000, 3'b000};
    vecs[14] = '{32'h7F800000, 32'h3F800000, 1'b1, 32'h7F800000, 3'b000};
    vecs[15] = '{32'h3F800000, 32'h7F800000, 1'b1, 32'hFF800000, 3'b000};
    vecs[16] = '{32'hFF800001, 32'h3F800000, 1'b0, 32'hFFC00001, 3'b100};
    vecs[17] = '{32'h3FC00000, 32'h3FC00000, 1'b0, 32'h40400000, 3'b000};
    vecs[18] = '{32'h7FC00001, 32'hFFC00000, 1'b0, 32'h7FC00001, 3'b000};
    vecs[19] = '{32'h3FFFFFFF, 32'h33800000, 1'b0, 32'h40000000, 3'b000};

    reset = 1'b0; valid = 1'b0; op = 1'b0; din1 = '0; din2 = '0;
    repeat (3) @(negedge clk);
    check("reset busy", 32'(busy), 32'(0));
    check("reset ready", 32'(ready), 32'(0));
    check("reset result", result, 32'h0);
    check("reset flags", 32'({flag_inv, flag_ovf, flag_unf}), 32'(0));
    reset = 1'b1;

    for (int i = 0; i < NV; i++)
      run_op(vecs[i].a, vecs[i].b, vecs[i].o, vecs[i].exp, vecs[i].fl, i);

    // A second request while busy must be dropped: one pulse, first result.
    @(negedge clk);
    din1 = 32'h40400000; din2 = 32'h3F800000; op = 1'b0; valid = 1'b1;
    @(posedge clk); #1; valid = 1'b0;
    @(negedge clk);
    din1 = 32'h3F800000; din2 = 32'h3F800000; op = 1'b0; valid = 1'b1;
    @(posedge clk); #1; valid = 1'b0;
    pulses = 0; seen = '0;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk); #1;
      if (ready) begin
        pulses++;
        seen = result;
      end
    end
    check("busy-drop pulses", 32'(pulses), 32'd1);
    check("busy-drop result", seen, 32'h40800000);

    // Reset in the third busy cycle clears everything at once.
    @(negedge clk);
    din1 = 32'h3F800000; din2 = 32'h3F800000; op = 1'b0; valid = 1'b1;
    @(posedge clk); #1; valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("midrst busy", 32'(busy), 32'(0));
    check("midrst ready", 32'(ready), 32'(0));
    check("midrst result", result, 32'h0);
    check("midrst flags", 32'({flag_inv, flag_ovf, flag_unf}), 32'(0));
    repeat (2) @(negedge clk);
    reset = 1'b1;
    pulses = 0;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      if (ready) pulses++;
    end
    check("midrst no pulse", 32'(pulses), 32'd0);
    run_op(32'h40400000, 32'h3F800000, 1'b0, 32'h40800000, 3'b000, 100);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
